// File: rtl/nios_project_pio_in.sv
// Avalon-MM parallel input port with two-flop synchronizers, per-bit debouncing,
// programmable rise/fall edge capture and a maskable level interrupt.
module nios_project_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DEB      = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_RAW      = 3'd5;

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] deb, deb_next;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_capture;
    logic [WIDTH-1:0] edge_set, edge_clr, wdata;
    logic             wr_en;
    logic [31:0]      read_mux;
    logic             unused_bits;

    assign wr_en       = chipselect && !write_n;
    assign wdata       = writedata[WIDTH-1:0];
    assign unused_bits = ^writedata;

    // A level is accepted only after it differs from deb for DEBOUNCE_CYCLES straight cycles.
    always_comb begin
        deb_next = deb;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (sync2[i] == deb[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                deb_next[i] = sync2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CW'(1);
            end
        end
    end

    assign edge_set = ((~deb & deb_next & rise_en) | (deb & ~deb_next & fall_en));
    assign edge_clr = (wr_en && address == ADDR_EDGE_CAP) ? wdata : '0;

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DEB:      read_mux = 32'(deb);
            ADDR_RISE_EN:  read_mux = 32'(rise_en);
            ADDR_MASK:     read_mux = 32'(irq_mask);
            ADDR_EDGE_CAP: read_mux = 32'(edge_capture);
            ADDR_FALL_EN:  read_mux = 32'(fall_en);
            ADDR_RAW:      read_mux = 32'(sync2);
            default:       read_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1        <= '0;
            sync2        <= '0;
            deb          <= '0;
            rise_en      <= '0;
            fall_en      <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            deb   <= deb_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (wr_en && address == ADDR_RISE_EN) rise_en  <= wdata;
            if (wr_en && address == ADDR_FALL_EN) fall_en  <= wdata;
            if (wr_en && address == ADDR_MASK)    irq_mask <= wdata;
            // A fresh edge wins over a simultaneous clear of the same bit.
            edge_capture <= (edge_capture & ~edge_clr) | edge_set;
            readdata     <= read_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_project_pio_in.sv
// Scoreboard bench for nios_project_pio_in (WIDTH=4, DEBOUNCE_CYCLES=4): stimulus
// queues hand-computed expectations, a negedge monitor pops and compares them.
module tb_nios_project_pio_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_irq;
        logic [31:0] exp;
        int          tag;
        string       name;
    } chk_t;

    chk_t sb[$];
    chk_t cur;

    nios_project_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input chk_t c);
        logic [31:0] act;
        act = c.is_irq ? {31'b0, irq} : readdata;
        n_checks++;
        if (c.tag != cyc) begin
            n_fail++;
            $display("[TB] FAIL %s: sampled at cycle %0d, scheduled for %0d", c.name, cyc, c.tag);
        end else if (act !== c.exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", c.name, act, c.exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            cur = sb.pop_front();
            check_output(cur);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input bit is_irq, input logic [31:0] exp, input string name);
        sb.push_back('{is_irq, exp, cyc + 1, name});
    endtask

    task automatic irq_chk(input bit e, input string name);
        push(1'b1, {31'b0, e}, name);
    endtask

    task automatic rd_chk(input int a, input logic [31:0] exp, input string name);
        address    = 3'(a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        push(1'b0, exp, name);
        tick();
        chipselect = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        address    = 3'(a);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic apply_stimulus();
        logic [31:0] raw_exp [6];
        raw_exp = '{32'h1, 32'h1, 32'h5, 32'h5, 32'h5, 32'h1};

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (3) tick();
        irq_chk(1'b0, "reset_irq");
        rd_chk(1, 32'h0, "reset_readdata");
        reset_n = 1'b1;

        // rising edge on bit 0: deb at k+5, capture and irq in the same cycle
        wr(1, 32'hF);
        wr(2, 32'h1);
        rd_chk(1, 32'hF, "rise_en_rd");
        rd_chk(2, 32'h1, "irq_mask_rd");
        for (int i = 0; i <= 6; i++) begin
            if (i == 0) in_port = 4'h1;
            irq_chk(i >= 5, $sformatf("rise_irq_%0d", i));
            rd_chk(0, (i >= 6) ? 32'h1 : 32'h0, $sformatf("rise_deb_%0d", i));
        end
        rd_chk(3, 32'h1, "rise_edge_cap");

        // 3-cycle glitch on bit 2 is visible raw but never debounced
        for (int j = 0; j < 6; j++) begin
            in_port = (j < 3) ? 4'h5 : 4'h1;
            rd_chk(5, raw_exp[j], $sformatf("glitch_raw_%0d", j));
        end
        tick(); tick(); tick(); tick();
        rd_chk(0, 32'h1, "glitch_deb");
        irq_chk(1'b1, "glitch_irq");
        rd_chk(3, 32'h1, "glitch_edge_cap");

        wr(3, 32'h1);
        irq_chk(1'b0, "clear_irq");
        rd_chk(3, 32'h0, "clear_edge_cap");

        // falling edge on bit 1, masked until irq_mask=0x2
        wr(4, 32'h2);
        wr(1, 32'h0);
        in_port = 4'h3;
        repeat (8) tick();
        rd_chk(0, 32'h3, "fall_setup_deb");
        rd_chk(3, 32'h0, "no_rise_capture");
        in_port = 4'h1;
        repeat (8) tick();
        irq_chk(1'b0, "fall_masked_irq");
        rd_chk(3, 32'h2, "fall_edge_cap");
        irq_chk(1'b1, "fall_unmasked_irq");
        wr(2, 32'h2);

        // build edge_capture=0x3 then clear bit 0 only
        wr(1, 32'h1);
        in_port = 4'h0;
        repeat (8) tick();
        in_port = 4'h1;
        repeat (8) tick();
        rd_chk(3, 32'h3, "both_edge_cap");
        wr(3, 32'h1);
        rd_chk(3, 32'h2, "partial_clear");

        // new bit-0 edge lands on the same edge as a clear of bit 0
        in_port = 4'h0;
        repeat (8) tick();
        in_port = 4'h1;
        for (int i = 0; i < 5; i++) rd_chk(3, 32'h2, $sformatf("pre_collide_%0d", i));
        wr(3, 32'h1);
        rd_chk(3, 32'h3, "collide_set_wins");

        // reset in the middle of a count (cnt=2), then input held high
        in_port = 4'h0;
        repeat (8) tick();
        in_port = 4'h1;
        repeat (4) tick();
        reset_n = 1'b0;
        irq_chk(1'b0, "midcount_rst_irq");
        tick();
        reset_n = 1'b1;
        for (int m = 1; m <= 7; m++) begin
            irq_chk(1'b0, $sformatf("post_rst_irq_%0d", m));
            rd_chk((m <= 4) ? m : 0, (m == 7) ? 32'h1 : 32'h0, $sformatf("post_rst_rd_%0d", m));
        end
        rd_chk(3, 32'h0, "post_rst_no_capture");
        rd_chk(5, 32'h1, "post_rst_raw");

        // RO and reserved addresses
        wr(0, 32'hF);
        rd_chk(0, 32'h1, "ro_write_ignored");
        wr(6, 32'hFFFF_FFFF);
        rd_chk(6, 32'h0, "reserved6");
        rd_chk(7, 32'h0, "reserved7");
    endtask

    initial begin
        apply_stimulus();
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            $display("[TB] FAIL drain: %0d checks never sampled, expected 0", sb.size());
            n_fail += sb.size();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/nios_project_pio_in.md
NIOS_PROJECT_PIO_IN -- requirements
Module: nios_project_pio_in

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of input bits (legal 1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000, consecutive stable cycles required to accept a new input level (legal 1..65535).
REQ-003 SHALL use one clock and a synchronous active-low reset: clk is the only clock; reset_n is sampled on the rising edge of clk.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port address, input, 3, Avalon register word address.
REQ-007 SHALL have port chipselect, input, 1, Avalon slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port in_port, input, WIDTH, asynchronous raw button/switch inputs.
REQ-011 SHALL have port readdata, output, 32, registered read data.
REQ-012 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-013 SHALL pass each in_port bit through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-014 SHALL keep a per-bit debounced level deb[i] and a per-bit counter cnt[i] of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-015 SHALL handle each cycle per bit as follows: if sync2 == deb, cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1, deb <= sync2 and cnt <= 0; else cnt <= cnt+1.
REQ-016 SHALL give this latency: a steady in_port change set up before clk edge k appears on deb at edge k+1+DEBOUNCE_CYCLES; any glitch shorter than DEBOUNCE_CYCLES synchronized cycles leaves deb unchanged.
REQ-017 SHALL use this register map. Address 0: deb (RO). Address 1: rise_en (RW). Address 2: irq_mask (RW). Address 3: edge_capture (write-1-to-clear). Address 4: fall_en (RW). Address 5: sync2 raw level (RO). Addresses 6-7 are reserved.
REQ-018 SHALL take RW registers from writedata[WIDTH-1:0] on the edge where chipselect=1, write_n=0 and address matches.
REQ-019 SHALL ignore writes to RO and reserved addresses.
REQ-020 SHALL set edge_capture[i] on the same clock edge deb[i] changes, when the change is 0->1 with rise_en[i]=1 or 1->0 with fall_en[i]=1.
REQ-021 SHALL clear edge_capture[i] when address 3 is written with writedata[i]=1 and leave bits written 0 unchanged.
REQ-022 SHALL keep edge_capture[i] set when a qualifying edge and a clear of that same bit occur in the same cycle.
REQ-023 SHALL apply changes to rise_en/fall_en to edges occurring from the following clock edge onward and SHALL NOT alter bits already captured.
REQ-024 SHALL drive irq = |(edge_capture & irq_mask) combinationally from registers, with no additional latency.
REQ-025 SHALL load readdata every clock with the addressed register, zero-extended to 32 bits; reserved addresses read 0; read latency is 1 cycle; reading has no side effects.

Reset
REQ-026 SHALL, while reset_n=0 at a clk edge, clear sync1, sync2, deb, cnt, rise_en, fall_en, irq_mask, edge_capture and readdata to 0, so irq=0.
REQ-027 SHALL abort any in-progress debounce count on reset; after reset, an input held at 1 is accepted DEBOUNCE_CYCLES+2 edges after reset release, with no edge captured unless rise_en was set by then.

Verification
REQ-028 SHALL cover the following with WIDTH=4 and DEBOUNCE_CYCLES=4.
- Write rise_en=0xF and irq_mask=0x1, then drive in_port 0x0->0x1 at edge k -> deb=0x1 at edge k+5, edge_capture=0x1 and irq=1 in the same cycle, and a read of address 3 returns 0x00000001.
- Drive a 3-cycle pulse on in_port[2] -> deb, edge_capture and irq are unchanged; address 5 shows the pulse.
- Set fall_en=0x2 and rise_en=0, then drive in_port[1] 1->0 -> edge_capture=0x2 and irq stays 0 until irq_mask=0x2 is written, then irq=1.
- With edge_capture=0x3, write 0x1 to address 3 -> edge_capture=0x2; in the cycle a new bit-0 edge coincides with a clear of bit 0 -> edge_capture[0]=1.
- Pulse reset_n=0 mid-count (cnt=2) -> all registers read 0 and irq=0, and the counter restarts from 0.
- Read addresses 6 and 7, and write 0xF to address 0 -> reads return 0 and deb is unchanged.
